// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch prefetch buffer.
// Exception codes, redirect selector encodings and the buffer entry layout.
package fetch_pkg;

  localparam logic [4:0] EXC_ADEL = 5'd4;

  typedef enum logic [1:0] {
    SEL_NONE   = 2'b00,
    SEL_BRANCH = 2'b01,
    SEL_EPC    = 2'b10,
    SEL_EXC    = 2'b11
  } redirect_sel_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic        filled;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_buf_if.sv
// Fetch-stage bus: instruction-memory request/response
// and the decode-side valid/ready handshake.
interface if_fetch_buf_if;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_exc;
  logic [4:0]  dec_exccode;
  logic [31:0] dec_badvaddr;

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output dec_valid, dec_inst, dec_pc,
    output dec_exc, dec_exccode, dec_badvaddr,
    input  dec_ready
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  dec_valid, dec_inst, dec_pc,
    input  dec_exc, dec_exccode, dec_badvaddr,
    output dec_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// In-order prefetch queue: allocate at tail, fill the oldest
// unfilled entry, pop the head, flush everything.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       alloc,
  input  fetch_entry_t               alloc_entry,
  input  logic                       fill,
  input  logic [31:0]                fill_inst,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [$clog2(DEPTH+1)-1:0] unfilled,
  output logic                       has_unfilled
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t   ent [DEPTH];
  logic [AW-1:0]  hd;
  logic [AW-1:0]  fp;
  logic [AW-1:0]  tl;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  ucnt;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      hd   <= '0;
      fp   <= '0;
      tl   <= '0;
      cnt  <= '0;
      ucnt <= '0;
    end else begin
      if (alloc) begin
        ent[tl] <= alloc_entry;
        tl      <= tl + 1'b1;
      end
      if (fill) begin
        ent[fp].inst   <= fill_inst;
        ent[fp].filled <= 1'b1;
        fp             <= fp + 1'b1;
      end
      // freed slots read as unfilled so dec_valid never sees stale data
      if (pop) begin
        ent[hd].filled <= 1'b0;
        hd             <= hd + 1'b1;
      end
      cnt  <= cnt + CW'(alloc) - CW'(pop);
      ucnt <= ucnt + CW'(alloc & ~alloc_entry.filled) - CW'(fill);
    end
  end

  assign head         = ent[hd];
  assign count        = cnt;
  assign unfilled     = ucnt;
  assign has_unfilled = (ucnt != '0);

endmodule

// File: rtl/if_fetch_buf.sv
// Instruction-fetch stage with a DEPTH-entry prefetch buffer,
// multiple outstanding fetches and redirect flushing.
module if_fetch_buf
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'hbfc00000,
  parameter logic [31:0] EXC_VECTOR = 32'hbfc00380,
  parameter int          DEPTH      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_sel,
  input  logic [31:0] branch_target,
  input  logic [31:0] cp0_epc_val,
  if_fetch_buf_if.master bus
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   req_addr;
  logic [31:0]   target;
  logic          req;
  logic          stop;
  logic          stale;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [CW-1:0] unfilled;
  logic          has_unfilled;
  fetch_entry_t  head;
  fetch_entry_t  new_ent;
  logic          redir;
  logic          accept;
  logic          dok;
  logic          fill;
  logic          pop;
  logic          alloc;
  logic          adel;
  logic          issue;
  logic          redir_issue;
  logic [CW:0]   inflight;
  logic [CW:0]   redir_disc;

  always_comb begin
    target = branch_target;
    unique case (1'b1)
      redirect_sel == SEL_EPC: target = cp0_epc_val;
      redirect_sel == SEL_EXC: target = EXC_VECTOR;
      default:                 target = branch_target;
    endcase
  end

  assign redir    = redirect_valid & (redirect_sel != SEL_NONE);
  assign accept   = req & bus.inst_addr_ok;
  assign dok      = bus.inst_data_ok;
  assign fill     = dok & (discard == '0) & has_unfilled;
  assign pop      = head.filled & bus.dec_ready;
  assign inflight = {1'b0, count} + {1'b0, discard};

  // everything accepted but not yet returned becomes discard on redirect
  assign redir_disc = {1'b0, discard} + {1'b0, unfilled}
                    + (CW+1)'(accept)
                    - (CW+1)'(dok & ((discard != '0) | has_unfilled));

  assign alloc = accept & ~stale & ~redir;
  assign adel  = ~redir & ~req & ~stop & (fetch_pc[1:0] != 2'b00)
               & ({1'b0, count} < LIMIT);
  assign issue = ~req & ~stop & (fetch_pc[1:0] == 2'b00)
               & (inflight < LIMIT);
  assign redir_issue = ~req & (target[1:0] == 2'b00)
                     & (redir_disc < LIMIT);

  always_comb begin
    new_ent = '{pc: req_addr, inst: '0, exc: 1'b0, filled: 1'b0};
    if (adel) new_ent = '{pc: fetch_pc, inst: '0, exc: 1'b1, filled: 1'b1};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req      <= 1'b0;
      req_addr <= '0;
      discard  <= '0;
      stop     <= 1'b0;
      stale    <= 1'b0;
    end else if (redir) begin
      fetch_pc <= target;
      stop     <= 1'b0;
      discard  <= CW'(redir_disc);
      stale    <= req & ~bus.inst_addr_ok;
      if (redir_issue) begin
        req      <= 1'b1;
        req_addr <= target;
      end else if (accept) begin
        req <= 1'b0;
      end
    end else begin
      if (accept) begin
        req   <= 1'b0;
        stale <= 1'b0;
        if (!stale) fetch_pc <= fetch_pc + 32'd4;
      end else if (issue) begin
        req      <= 1'b1;
        req_addr <= fetch_pc;
      end
      if (adel) stop <= 1'b1;
      discard <= discard + CW'(accept & stale)
               - CW'(dok & (discard != '0));
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .flush        (redir),
    .alloc        (alloc | adel),
    .alloc_entry  (new_ent),
    .fill         (fill),
    .fill_inst    (bus.inst_rdata),
    .pop          (pop),
    .head         (head),
    .count        (count),
    .unfilled     (unfilled),
    .has_unfilled (has_unfilled)
  );

  assign bus.inst_req     = req;
  assign bus.inst_addr    = req_addr;
  assign bus.dec_valid    = head.filled;
  assign bus.dec_inst     = head.filled ? head.inst : '0;
  assign bus.dec_pc       = head.filled ? head.pc : '0;
  assign bus.dec_exc      = head.filled & head.exc;
  assign bus.dec_exccode  = (head.filled & head.exc) ? EXC_ADEL : 5'd0;
  assign bus.dec_badvaddr = (head.filled & head.exc) ? head.pc : '0;

endmodule
